pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the CPU fetch stage; successor to the single-vector 8-bit PC. Adds memory-fetched reset and interrupt vectors via a request/valid handshake, multi-line prioritised interrupts with a global enable, and a hardware return-address stack for CALL/RET/RTI. It sits between the decode/control unit, which supplies `op`, `len` and `target`, and the instruction-memory port used for vector reads.

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_sequencer_if.sv | 12 +
 rtl/pc_return_stack.sv | 40 ++++
 rtl/pc_sequencer.sv | 141 ++++++++++++++
 tb/tb_pc_sequencer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: op encoding, FSM states, width defaults.
package pc_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int LEN_W_DEF  = 2;

    localparam logic [2:0] OP_SEQ  = 3'd0;
    localparam logic [2:0] OP_JUMP = 3'd1;
    localparam logic [2:0] OP_CALL = 3'd2;
    localparam logic [2:0] OP_RET  = 3'd3;
    localparam logic [2:0] OP_RTI  = 3'd4;
    localparam logic [2:0] OP_EI   = 3'd5;
    localparam logic [2:0] OP_DI   = 3'd6;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_VEC_WAIT = 1'b1
    } state_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// Vector-read port between the PC sequencer and the instruction-memory side.
interface pc_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              vec_req;
    logic [ADDR_W-1:0] vec_addr;
    logic [ADDR_W-1:0] vec_data;
    logic              vec_valid;

    modport master (output vec_req, vec_addr, input vec_data, vec_valid);
    modport slave  (input vec_req, vec_addr, output vec_data, vec_valid);
endinterface

// File: rtl/pc_return_stack.sv
// Hardware return-address stack; the caller decides whether a push/pop is legal.
module pc_return_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] wdata,
    output logic [ADDR_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign wr_idx = IDX_W'(count);
    assign rd_idx = IDX_W'(count - 1'b1);
    assign full   = (count == CNT_W'(STACK_DEPTH));
    assign empty  = (count == '0);
    assign rdata  = mem[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    count <= '0;
        else if (clr)               count <= '0;
        else if (push && !full)     count <= count + 1'b1;
        else if (pop && !empty)     count <= count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!clr && push && !full) mem[wr_idx] <= wdata;
    end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with memory-fetched reset/IRQ vectors,
// prioritised interrupts and a return-address stack.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int LEN_W          = LEN_W_DEF,
    parameter int STACK_DEPTH    = 4,
    parameter int NUM_IRQ        = 4,
    parameter int RESET_VEC_ADDR = 0,
    parameter int IRQ_VEC_BASE   = 1,
    parameter int CNT_W          = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reset_in,
    input  logic               pc_write,
    input  logic [2:0]         op,
    input  logic [LEN_W-1:0]   len,
    input  logic [ADDR_W-1:0]  target,
    input  logic [NUM_IRQ-1:0] irq,
    pc_sequencer_if.master     vec,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               irq_enable,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic [CNT_W-1:0]   stack_count,
    output logic               stack_ovf,
    output logic               stack_unf
);
    state_t             state, state_n;
    logic [ADDR_W-1:0]  pc_n, vec_addr_q, vec_addr_n;
    logic [ADDR_W-1:0]  seq_pc, nxt, rdata, wdata, irq_vec;
    logic [NUM_IRQ-1:0] ack_n, irq_onehot;
    logic               ie_n, ovf_n, unf_n, push, pop, clr, full, empty;
    logic               op_flow, irq_take;

    pc_return_stack #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH), .CNT_W(CNT_W)) u_stack (
        .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop), .wdata(wdata),
        .rdata(rdata), .count(stack_count), .full(full), .empty(empty)
    );

    assign seq_pc       = pc + ADDR_W'(len);
    assign nxt          = (op == OP_JUMP) ? target : seq_pc;
    assign op_flow      = (op == OP_SEQ) || (op == OP_JUMP) || (op == 3'd7);
    assign irq_take     = (state == ST_RUN) && pc_write && op_flow && irq_enable && (irq != '0);
    assign irq_onehot   = irq & (~irq + 1'b1);
    assign busy         = (state == ST_VEC_WAIT);
    assign vec.vec_req  = (state == ST_VEC_WAIT);
    assign vec.vec_addr = vec_addr_q;

    // Scan high-to-low so the lowest active line wins.
    always_comb begin
        irq_vec = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (irq[i]) irq_vec = ADDR_W'(IRQ_VEC_BASE + i);
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        vec_addr_n = vec_addr_q;
        ie_n       = irq_enable;
        ack_n      = '0;
        ovf_n      = stack_ovf;
        unf_n      = stack_unf;
        push       = 1'b0;
        pop        = 1'b0;
        clr        = 1'b0;
        wdata      = seq_pc;
        if (reset_in) begin
            state_n    = ST_VEC_WAIT;
            pc_n       = '0;
            vec_addr_n = ADDR_W'(RESET_VEC_ADDR);
            ie_n       = 1'b0;
            ovf_n      = 1'b0;
            unf_n      = 1'b0;
            clr        = 1'b1;
        end else if (state == ST_VEC_WAIT) begin
            if (vec.vec_valid) begin
                pc_n    = vec.vec_data;
                state_n = ST_RUN;
            end
        end else if (pc_write) begin
            if (irq_take) begin
                // The interrupted op's own result becomes the return address.
                wdata      = nxt;
                push       = !full;
                ovf_n      = stack_ovf | full;
                ie_n       = 1'b0;
                ack_n      = irq_onehot;
                vec_addr_n = irq_vec;
                state_n    = ST_VEC_WAIT;
            end else begin
                unique case (op)
                    OP_JUMP: pc_n = target;
                    OP_CALL: begin
                        push  = !full;
                        ovf_n = stack_ovf | full;
                        pc_n  = target;
                    end
                    OP_RET, OP_RTI: begin
                        pop   = !empty;
                        unf_n = stack_unf | empty;
                        pc_n  = empty ? seq_pc : rdata;
                        if (op == OP_RTI) ie_n = 1'b1;
                    end
                    OP_EI: begin
                        pc_n = seq_pc;
                        ie_n = 1'b1;
                    end
                    OP_DI: begin
                        pc_n = seq_pc;
                        ie_n = 1'b0;
                    end
                    default: pc_n = seq_pc;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_VEC_WAIT;
            pc         <= '0;
            vec_addr_q <= ADDR_W'(RESET_VEC_ADDR);
            irq_enable <= 1'b0;
            irq_ack    <= '0;
            stack_ovf  <= 1'b0;
            stack_unf  <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            vec_addr_q <= vec_addr_n;
            irq_enable <= ie_n;
            irq_ack    <= ack_n;
            stack_ovf  <= ovf_n;
            stack_unf  <= unf_n;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a queue-based behavioural model.
module tb_pc_sequencer;
    logic       clk = 1'b0;
    logic       rst, reset_in, pc_write;
    logic [2:0] op;
    logic [1:0] len;
    logic [7:0] target, pc;
    logic [3:0] irq, irq_ack;
    logic [2:0] stack_count;
    logic       busy, irq_enable, stack_ovf, stack_unf;

    int checks = 0;
    int fails  = 0;

    // Behavioural model state
    bit         m_run, m_ie, m_ovf, m_unf;
    logic [7:0] m_pc, m_vaddr;
    logic [3:0] m_ack;
    logic [7:0] m_stk[$];

    pc_sequencer_if #(.ADDR_W(8)) vif();

    pc_sequencer dut (
        .clk(clk), .rst(rst), .reset_in(reset_in), .pc_write(pc_write), .op(op), .len(len),
        .target(target), .irq(irq), .vec(vif), .pc(pc), .busy(busy), .irq_enable(irq_enable),
        .irq_ack(irq_ack), .stack_count(stack_count), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_run = 0; m_pc = 8'h00; m_vaddr = 8'h00; m_ie = 0;
        m_ack = 4'h0; m_ovf = 0; m_unf = 0; m_stk.delete();
    endtask

    task automatic model_push(input logic [7:0] v);
        if (m_stk.size() < 4) m_stk.push_back(v);
        else m_ovf = 1;
    endtask

    task automatic model_step();
        logic [7:0] seqv, nxt;
        int sel;
        m_ack = 4'h0;
        if (reset_in) model_reset();
        else if (!m_run) begin
            if (vif.vec_valid) begin m_pc = vif.vec_data; m_run = 1; end
        end else if (pc_write) begin
            seqv = m_pc + {6'd0, len};
            nxt  = (op == 3'd1) ? target : seqv;
            if ((op == 3'd0 || op == 3'd1) && m_ie && irq != 4'h0) begin
                sel = 0;
                while (!irq[sel]) sel++;
                model_push(nxt);
                m_ie = 0; m_ack = 4'(1 << sel); m_vaddr = 8'(1 + sel); m_run = 0;
            end else begin
                case (op)
                    3'd1: m_pc = target;
                    3'd2: begin model_push(seqv); m_pc = target; end
                    3'd3, 3'd4: begin
                        if (m_stk.size() == 0) begin m_pc = seqv; m_unf = 1; end
                        else m_pc = m_stk.pop_back();
                        if (op == 3'd4) m_ie = 1;
                    end
                    3'd5: begin m_pc = seqv; m_ie = 1; end
                    3'd6: begin m_pc = seqv; m_ie = 0; end
                    default: m_pc = seqv;
                endcase
            end
        end
    endtask

    // One clock with the given inputs; outputs sampled 1ns after the edge.
    task automatic cyc(input bit pw, input logic [2:0] o, input logic [1:0] l, input logic [7:0] t,
                       input logic [3:0] iq, input bit rin, input bit vv, input logic [7:0] vd);
        pc_write = pw; op = o; len = l; target = t; irq = iq; reset_in = rin;
        vif.vec_valid = vv; vif.vec_data = vd;
        model_step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1; reset_in = 0; pc_write = 0; op = 0; len = 0; target = 0; irq = 0;
        vif.vec_valid = 0; vif.vec_data = 0;
        model_reset();
        @(posedge clk); #1;
        checks++; if (pc !== 8'h00 || busy !== 1'b1 || vif.vec_addr !== 8'h00) begin fails++;
            $display("FAIL reset_state: pc=%h busy=%b vec_addr=%h want 00/1/00", pc, busy, vif.vec_addr); end
        checks++; if (irq_enable !== 1'b0 || stack_count !== 3'd0 || irq_ack !== 4'h0 || stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin fails++;
            $display("FAIL reset_flags: ie=%b cnt=%0d ack=%h ovf=%b unf=%b want all 0", irq_enable, stack_count, irq_ack, stack_ovf, stack_unf); end
        rst = 0;
        repeat (3) cyc(1, 3'd1, 2'd1, 8'h77, 4'hF, 0, 0, 8'h00);
        checks++; if (busy !== 1'b1 || vif.vec_req !== 1'b1 || vif.vec_addr !== 8'h00 || pc !== 8'h00) begin fails++;
            $display("FAIL reset_wait: busy=%b req=%b vec_addr=%h pc=%h want 1/1/00/00", busy, vif.vec_req, vif.vec_addr, pc); end
        cyc(0, 3'd0, 2'd0, 8'h00, 4'h0, 0, 1, 8'h20);
        checks++; if (pc !== 8'h20 || busy !== 1'b0 || irq_enable !== 1'b0) begin fails++;
            $display("FAIL reset_vector: pc=%h busy=%b ie=%b want 20/0/0", pc, busy, irq_enable); end
    endtask

    task automatic test_seq_call_ret();
        cyc(1, 3'd0, 2'd2, 8'h00, 4'h0, 0, 0, 8'h00);
        checks++; if (pc !== 8'h22) begin fails++; $display("FAIL seq_len2: pc=%h want 22", pc); end
        cyc(1, 3'd2, 2'd2, 8'h50, 4'h0, 0, 0, 8'h00);
        checks++; if (pc !== 8'h50 || stack_count !== 3'd1) begin fails++;
            $display("FAIL call: pc=%h cnt=%0d want 50/1", pc, stack_count); end
        cyc(1, 3'd3, 2'd1, 8'h00, 4'h0, 0, 0, 8'h00);
        checks++; if (pc !== 8'h24 || stack_count !== 3'd0) begin fails++;
            $display("FAIL ret: pc=%h cnt=%0d want 24/0", pc, stack_count); end
    endtask

    task automatic test_irq();
        cyc(1, 3'd1, 2'd0, 8'h30, 4'h0, 0, 0, 8'h00);
        cyc(1, 3'd5, 2'd0, 8'h00, 4'h0, 0, 0, 8'h00);
        checks++; if (irq_enable !== 1'b1 || pc !== 8'h30) begin fails++;
            $display("FAIL ei: ie=%b pc=%h want 1/30", irq_enable, pc); end
        cyc(1, 3'd0, 2'd1, 8'h00, 4'b0110, 0, 0, 8'h00);
        checks++; if (irq_ack !== 4'b0010 || vif.vec_addr !== 8'h02 || busy !== 1'b1) begin fails++;
            $display("FAIL irq_accept: ack=%b vec_addr=%h busy=%b want 0010/02/1", irq_ack, vif.vec_addr, busy); end
        checks++; if (pc !== 8'h30 || irq_enable !== 1'b0 || stack_count !== 3'd1) begin fails++;
            $display("FAIL irq_state: pc=%h ie=%b cnt=%0d want 30/0/1", pc, irq_enable, stack_count); end
        cyc(0, 3'd0, 2'd0, 8'h00, 4'b0110, 0, 0, 8'h00);
        checks++; if (irq_ack !== 4'h0 || busy !== 1'b1) begin fails++;
            $display("FAIL irq_ack_pulse: ack=%b busy=%b want 0000/1", irq_ack, busy); end
        cyc(0, 3'd0, 2'd0, 8'h00, 4'h0, 0, 1, 8'h80);
        checks++; if (pc !== 8'h80 || busy !== 1'b0) begin fails++;
            $display("FAIL irq_vector: pc=%h busy=%b want 80/0", pc, busy); end
        cyc(1, 3'd4, 2'd1, 8'h00, 4'h0, 0, 0, 8'h00);
        checks++; if (pc !== 8'h31 || irq_enable !== 1'b1 || stack_count !== 3'd0) begin fails++;
            $display("FAIL rti: pc=%h ie=%b cnt=%0d want 31/1/0", pc, irq_enable, stack_count); end
        cyc(1, 3'd6, 2'd0, 8'h00, 4'h0, 0, 0, 8'h00);
    endtask

    task automatic test_stack_limits();
        for (int i = 0; i < 5; i++) cyc(1, 3'd2, 2'd1, 8'(8'h40 + i * 16), 4'h0, 0, 0, 8'h00);
        checks++; if (stack_count !== 3'd4 || stack_ovf !== 1'b1 || pc !== 8'h80) begin fails++;
            $display("FAIL call_overflow: cnt=%0d ovf=%b pc=%h want 4/1/80", stack_count, stack_ovf, pc); end
        cyc(1, 3'd3, 2'd1, 8'h00, 4'h0, 0, 0, 8'h00);
        checks++; if (pc !== 8'h61 || stack_unf !== 1'b0) begin fails++;
            $display("FAIL ret_first: pc=%h unf=%b want 61/0", pc, stack_unf); end
        repeat (3) cyc(1, 3'd3, 2'd1, 8'h00, 4'h0, 0, 0, 8'h00);
        checks++; if (pc !== 8'h32 || stack_count !== 3'd0) begin fails++;
            $display("FAIL ret_fourth: pc=%h cnt=%0d want 32/0", pc, stack_count); end
        cyc(1, 3'd3, 2'd1, 8'h00, 4'h0, 0, 0, 8'h00);
        checks++; if (pc !== 8'h33 || stack_unf !== 1'b1 || stack_ovf !== 1'b1) begin fails++;
            $display("FAIL ret_underflow: pc=%h unf=%b ovf=%b want 33/1/1", pc, stack_unf, stack_ovf); end
    endtask

    task automatic test_reset_in();
        cyc(1, 3'd5, 2'd0, 8'h00, 4'h0, 0, 0, 8'h00);
        cyc(1, 3'd0, 2'd1, 8'h00, 4'b1001, 0, 0, 8'h00);
        checks++; if (busy !== 1'b1 || vif.vec_addr !== 8'h01 || irq_ack !== 4'b0001) begin fails++;
            $display("FAIL irq0_accept: busy=%b vec_addr=%h ack=%b want 1/01/0001", busy, vif.vec_addr, irq_ack); end
        cyc(0, 3'd0, 2'd0, 8'h00, 4'h0, 1, 1, 8'hAA);
        checks++; if (vif.vec_addr !== 8'h00 || busy !== 1'b1 || pc !== 8'h00 || stack_count !== 3'd0) begin fails++;
            $display("FAIL reset_in: vec_addr=%h busy=%b pc=%h cnt=%0d want 00/1/00/0", vif.vec_addr, busy, pc, stack_count); end
        checks++; if (stack_ovf !== 1'b0 || stack_unf !== 1'b0 || irq_enable !== 1'b0) begin fails++;
            $display("FAIL reset_in_flags: ovf=%b unf=%b ie=%b want 0/0/0", stack_ovf, stack_unf, irq_enable); end
        cyc(0, 3'd0, 2'd0, 8'h00, 4'h0, 0, 1, 8'h20);
        checks++; if (pc !== 8'h20 || busy !== 1'b0) begin fails++;
            $display("FAIL reset_in_refetch: pc=%h busy=%b want 20/0", pc, busy); end
    endtask

    task automatic test_wrap_stall();
        cyc(1, 3'd1, 2'd0, 8'hFF, 4'h0, 0, 0, 8'h00);
        cyc(1, 3'd0, 2'd2, 8'h00, 4'h0, 0, 0, 8'h00);
        checks++; if (pc !== 8'h01) begin fails++; $display("FAIL wrap: pc=%h want 01", pc); end
        cyc(1, 3'd5, 2'd0, 8'h00, 4'h0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 3'd0, 2'd3, 8'h00, 4'hF, 0, 0, 8'h00);
            checks++; if (pc !== 8'h01 || irq_ack !== 4'h0 || busy !== 1'b0) begin fails++;
                $display("FAIL stall[%0d]: pc=%h ack=%b busy=%b want 01/0000/0", i, pc, irq_ack, busy); end
        end
        cyc(1, 3'd6, 2'd0, 8'h00, 4'h0, 0, 0, 8'h00);
    endtask

    task automatic test_random();
        logic [27:0] act, exp;
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 6)), 2'($urandom),
                8'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                ($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0), 8'($urandom));
            act = {pc, busy, vif.vec_req, vif.vec_addr, irq_enable, irq_ack, stack_count, stack_ovf, stack_unf};
            exp = {m_pc, !m_run, !m_run, m_vaddr, m_ie, m_ack, 3'(m_stk.size()), m_ovf, m_unf};
            checks++; if (act !== exp) begin fails++;
                $display("FAIL random[%0d]: got pc/busy/req/vaddr/ie/ack/cnt/ovf/unf=%h want %h", n, act, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_seq_call_ret();
        test_irq();
        test_stack_limits();
        test_reset_in();
        test_wrap_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
